// File: rtl/segment_display_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment driver.
package segment_display_pkg;

  localparam int NUM_DIGITS = 4;

  // Per-digit code: [3:0] hex nibble, [4] decimal point.
  typedef logic [4:0] digit_code_t;

  // Segment drive pattern, active-high: [6:0] segments a..g, [7] decimal point.
  typedef logic [7:0] seg_pattern_t;

  // Segment bit positions within seg_pattern_t.
  localparam int SEG_A  = 0;  // top
  localparam int SEG_B  = 1;  // upper-right
  localparam int SEG_C  = 2;  // lower-right
  localparam int SEG_D  = 3;  // bottom
  localparam int SEG_E  = 4;  // lower-left
  localparam int SEG_F  = 5;  // upper-left
  localparam int SEG_G  = 6;  // middle
  localparam int SEG_DP = 7;  // decimal point

  // Bit position of the decimal-point flag inside a digit code.
  localparam int CODE_DP = 4;

endpackage

// File: rtl/segment_display_hex_to_seg.sv
// Combinational nibble + decimal-point to seven-segment pattern decoder.
module hex_to_seg
  import segment_display_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);

  seg_pattern_t seg_s;

  // Hex glyph lookup; the decimal point passes straight through from the code.
  always_comb begin
    seg_s = 8'h00;
    case (code[3:0])
      4'h0:    seg_s[SEG_G:SEG_A] = 7'h3F;
      4'h1:    seg_s[SEG_G:SEG_A] = 7'h06;
      4'h2:    seg_s[SEG_G:SEG_A] = 7'h5B;
      4'h3:    seg_s[SEG_G:SEG_A] = 7'h4F;
      4'h4:    seg_s[SEG_G:SEG_A] = 7'h66;
      4'h5:    seg_s[SEG_G:SEG_A] = 7'h6D;
      4'h6:    seg_s[SEG_G:SEG_A] = 7'h7D;
      4'h7:    seg_s[SEG_G:SEG_A] = 7'h07;
      4'h8:    seg_s[SEG_G:SEG_A] = 7'h7F;
      4'h9:    seg_s[SEG_G:SEG_A] = 7'h6F;
      4'hA:    seg_s[SEG_G:SEG_A] = 7'h77;
      4'hB:    seg_s[SEG_G:SEG_A] = 7'h7C;
      4'hC:    seg_s[SEG_G:SEG_A] = 7'h39;
      4'hD:    seg_s[SEG_G:SEG_A] = 7'h5E;
      4'hE:    seg_s[SEG_G:SEG_A] = 7'h79;
      4'hF:    seg_s[SEG_G:SEG_A] = 7'h71;
      default: seg_s[SEG_G:SEG_A] = 7'h00;
    endcase
    seg_s[SEG_DP] = code[CODE_DP];
  end

  assign seg = seg_s;

endmodule

// File: rtl/segment_display.sv
// Time-multiplexed 4-digit seven-segment driver. A prescaler holds each digit
// for SCAN_DIV clocks; the selected digit is decoded and both the digit enable
// and the segment pattern are registered so no input reaches a pin combinationally.
module segment_display
  import segment_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  digit_code_t  Values [0:NUM_DIGITS-1],
  output logic [3:0]   EnableOuts,
  output logic [7:0]   SegOuts
);

  // Prescaler width: enough to count 0..SCAN_DIV-1, never narrower than one bit.
  localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 32'd1);

  logic [1:0]      idx_r;
  logic [PC_W-1:0] pc_r;
  logic [3:0]      enable_r;
  seg_pattern_t    seg_r;

  digit_code_t     digit_s;
  seg_pattern_t    seg_s;

  // The digit currently being scanned is sampled live, not latched per frame.
  assign digit_s = Values[idx_r];

  hex_to_seg u_hex_to_seg (
    .code (digit_s),
    .seg  (seg_s)
  );

  // Scan sequencer and output registers; outputs reflect the pre-edge digit index.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_r    <= 2'd0;
      pc_r     <= '0;
      enable_r <= 4'b0000;
      seg_r    <= 8'h00;
    end else begin
      enable_r <= 4'b0001 << idx_r;
      seg_r    <= seg_s;
      if (pc_r == PC_LAST) begin
        pc_r  <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        pc_r  <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign EnableOuts = enable_r;
  assign SegOuts    = seg_r;

endmodule

// File: tb/tb_segment_display.sv
// Directed, scoreboard-based bench for segment_display at SCAN_DIV = 1, 3 and 4.
module tb_segment_display;

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] seg;
  } exp_t;

  logic clk;
  logic rst1, rst3, rst4;
  logic [4:0] val1 [0:3];
  logic [4:0] val3 [0:3];
  logic [4:0] val4 [0:3];
  logic [3:0] en1, en3, en4;
  logic [7:0] seg1, seg3, seg4;

  int checks = 0;
  int failures = 0;
  exp_t sb [$];

  // Reference glyphs for nibbles 0..F (segments g..a).
  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  segment_display #(.SCAN_DIV(1)) dut1 (
    .Clk(clk), .Reset(rst1), .Values(val1), .EnableOuts(en1), .SegOuts(seg1));
  segment_display #(.SCAN_DIV(3)) dut3 (
    .Clk(clk), .Reset(rst3), .Values(val3), .EnableOuts(en3), .SegOuts(seg3));
  segment_display #(.SCAN_DIV(4)) dut4 (
    .Clk(clk), .Reset(rst4), .Values(val4), .EnableOuts(en4), .SegOuts(seg4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] en, input logic [7:0] seg);
    exp_t e;
    e.en = en;
    e.seg = seg;
    sb.push_back(e);
  endtask

  task automatic check(input int sel, input string tag);
    exp_t e;
    exp_t o;
    case (sel)
      1: o = '{en: en1, seg: seg1};
      3: o = '{en: en3, seg: seg3};
      default: o = '{en: en4, seg: seg4};
    endcase
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed en=%b seg=%h", tag, o.en, o.seg);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed en=%b seg=%h expected en=%b seg=%h",
               tag, o.en, o.seg, e.en, e.seg);
      end
    end
  endtask

  initial begin
    int slot;
    logic [3:0] en_e;
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      val1[i] = 5'h00; val3[i] = 5'h00; val4[i] = 5'h00;
    end

    // Reset blanking with Values all zero, then first digit after release.
    #2;
    push_exp(4'b0000, 8'h00); check(1, "reset_blank");
    tick();
    push_exp(4'b0000, 8'h00); check(1, "reset_held");
    @(negedge clk); rst1 = 1'b0;
    push_exp(4'b0001, 8'h3F); tick(); check(1, "reset_first_edge");

    // Scan order at SCAN_DIV=1, two full frames.
    rst1 = 1'b1;
    val1[0] = 5'h05; val1[1] = 5'h15; val1[2] = 5'h0A; val1[3] = 5'h1F;
    @(negedge clk); rst1 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      push_exp(4'b0001, 8'h6D); tick(); check(1, "scan_d0");
      push_exp(4'b0010, 8'hED); tick(); check(1, "scan_d1");
      push_exp(4'b0100, 8'h77); tick(); check(1, "scan_d2");
      push_exp(4'b1000, 8'hF1); tick(); check(1, "scan_d3");
    end

    // Reset mid-operation while digit 2 is shown.
    rst1 = 1'b1; #1;
    @(negedge clk); rst1 = 1'b0;
    tick(); tick();
    push_exp(4'b0100, 8'h77); tick(); check(1, "midrst_before");
    rst1 = 1'b1; #1;
    push_exp(4'b0000, 8'h00); check(1, "midrst_blank");
    @(negedge clk); rst1 = 1'b0;
    push_exp(4'b0001, 8'h6D); tick(); check(1, "midrst_resume");

    // Full decode sweep on all digits, dp=0 then dp=1.
    rst1 = 1'b1; #1;
    @(negedge clk); rst1 = 1'b0;
    slot = 0;
    for (int dp = 0; dp < 2; dp++) begin
      for (int n = 0; n < 16; n++) begin
        for (int i = 0; i < 4; i++) val1[i] = {dp[0], n[3:0]};
        en_e = 4'b0001 << (slot % 4);
        push_exp(en_e, {dp[0], glyph[n]});
        tick(); check(1, "decode_sweep");
        slot++;
      end
    end

    // Prescaler hold at SCAN_DIV=3 across two frames.
    val3[0] = 5'h00; val3[1] = 5'h01; val3[2] = 5'h02; val3[3] = 5'h03;
    @(negedge clk); rst3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      en_e = 4'b0001 << ((k / 3) % 4);
      push_exp(en_e, {1'b0, glyph[(k / 3) % 4]});
      tick(); check(3, "hold3");
    end

    // Mid-slot value change at SCAN_DIV=4.
    for (int i = 0; i < 4; i++) val4[i] = 5'h08;
    @(negedge clk); rst4 = 1'b0;
    push_exp(4'b0001, 8'h7F); tick(); check(4, "midslot_pre0");
    push_exp(4'b0001, 8'h7F); tick(); check(4, "midslot_pre1");
    val4[0] = 5'h01;
    push_exp(4'b0001, 8'h06); tick(); check(4, "midslot_change");
    push_exp(4'b0001, 8'h06); tick(); check(4, "midslot_hold");
    push_exp(4'b0010, 8'h7F); tick(); check(4, "midslot_next");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
